// File: rtl/dmem_responder_if.sv
// Memory-operation bus between the core (master) and the data-memory responder (slave):
// a single-outstanding request channel plus a valid/yumi response channel.
interface dmem_responder_if #(
    parameter int DATA_W = 32
);
    logic              req_valid_i;
    logic              req_ready_o;
    logic              req_is_store_i;
    logic              req_is_byte_i;
    logic [31:0]       req_addr_i;
    logic [DATA_W-1:0] req_wdata_i;
    logic              resp_valid_o;
    logic [DATA_W-1:0] resp_data_o;
    logic              resp_err_o;
    logic              resp_yumi_i;

    modport master (
        output req_valid_i, req_is_store_i, req_is_byte_i, req_addr_i, req_wdata_i, resp_yumi_i,
        input  req_ready_o, resp_valid_o, resp_data_o, resp_err_o
    );

    modport slave (
        input  req_valid_i, req_is_store_i, req_is_byte_i, req_addr_i, req_wdata_i, resp_yumi_i,
        output req_ready_o, resp_valid_o, resp_data_o, resp_err_o
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: word-organised RAM serving LW/LBU/SW/SB one request at a time,
// with byte extraction for LBU, read-modify-write for SB and a registered response.
module dmem_responder #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    dmem_responder_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t              state, state_n;
    logic                is_store, is_byte;
    logic [ADDR_W+1:0]   addr;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W-1:0]   rdata;
    logic                resp_valid, resp_valid_n;
    logic                resp_err, resp_err_n;
    logic [DATA_W-1:0]   resp_data, resp_data_n;
    logic                capture, rd_en, wr_en;
    logic [DATA_W-1:0]   wr_word, rd_word;
    logic [ADDR_W-1:0]   word_idx;
    logic [1:0]          lane;

    logic [DATA_W-1:0]   mem [0:(1<<ADDR_W)-1];

    function automatic logic [DATA_W-1:0] load_fmt(input logic [DATA_W-1:0] word,
                                                   input logic byte_op, input logic [1:0] ln);
        if (byte_op) return {{(DATA_W-8){1'b0}}, word[ln*8 +: 8]};
        return word;
    endfunction

    function automatic logic [DATA_W-1:0] merge_byte(input logic [DATA_W-1:0] word,
                                                     input logic [7:0] b, input logic [1:0] ln);
        logic [DATA_W-1:0] res;
        res = word;
        res[ln*8 +: 8] = b;
        return res;
    endfunction

    assign word_idx = addr[ADDR_W+1:2];
    assign lane     = addr[1:0];
    assign rd_word  = mem[word_idx];

    assign bus.req_ready_o  = (state == IDLE);
    assign bus.resp_valid_o = resp_valid;
    assign bus.resp_err_o   = resp_err;
    assign bus.resp_data_o  = resp_data;

    always_comb begin
        state_n      = state;
        capture      = 1'b0;
        rd_en        = 1'b0;
        wr_en        = 1'b0;
        wr_word      = wdata;
        resp_valid_n = resp_valid;
        resp_err_n   = resp_err;
        resp_data_n  = resp_data;
        case (state)
            IDLE: begin
                if (bus.req_valid_i) begin
                    capture = 1'b1;
                    // Misaligned word accesses complete immediately without touching the RAM
                    if (!bus.req_is_byte_i && bus.req_addr_i[1:0] != 2'b00) begin
                        state_n      = RESP;
                        resp_valid_n = 1'b1;
                        resp_err_n   = 1'b1;
                        resp_data_n  = '0;
                    end else if (bus.req_is_store_i && !bus.req_is_byte_i) begin
                        state_n = WR;
                    end else begin
                        state_n = RD;
                    end
                end
            end
            RD: begin
                rd_en = 1'b1;
                if (is_store) begin
                    state_n = WR;
                end else begin
                    state_n      = RESP;
                    resp_valid_n = 1'b1;
                    resp_err_n   = 1'b0;
                    resp_data_n  = load_fmt(rd_word, is_byte, lane);
                end
            end
            WR: begin
                wr_en        = 1'b1;
                wr_word      = is_byte ? merge_byte(rdata, wdata[7:0], lane) : wdata;
                state_n      = RESP;
                resp_valid_n = 1'b1;
                resp_err_n   = 1'b0;
                resp_data_n  = '0;
            end
            RESP: begin
                if (bus.resp_yumi_i) begin
                    state_n      = IDLE;
                    resp_valid_n = 1'b0;
                    resp_err_n   = 1'b0;
                    resp_data_n  = '0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            is_store   <= 1'b0;
            is_byte    <= 1'b0;
            addr       <= '0;
            wdata      <= '0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_data  <= '0;
        end else begin
            state      <= state_n;
            resp_valid <= resp_valid_n;
            resp_err   <= resp_err_n;
            resp_data  <= resp_data_n;
            if (capture) begin
                is_store <= bus.req_is_store_i;
                is_byte  <= bus.req_is_byte_i;
                addr     <= bus.req_addr_i[ADDR_W+1:0];
                wdata    <= bus.req_wdata_i;
            end
        end
    end

    // RAM array and its read register; a write whose edge sees reset high is dropped
    always_ff @(posedge clk) begin
        if (rd_en) rdata <= rd_word;
        if (wr_en && !reset) mem[word_idx] <= wr_word;
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: vector table of requests with expected data,
// error flag and latency, plus hand-written hold, reset-during-write and reset checks.
module tb_dmem_responder;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dmem_responder_if #(.DATA_W(32)) bus();

    dmem_responder #(.ADDR_W(10), .DATA_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        string       name;
        logic        st;
        logic        by;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge.
    task automatic do_req(input logic st, input logic by, input logic [31:0] a,
                          input logic [31:0] wd, input bit auto_yumi,
                          output logic [31:0] data, output logic err, output int lat);
        check("ready_before_req", {31'b0, bus.req_ready_o}, 32'd1);
        bus.req_valid_i    = 1'b1;
        bus.req_is_store_i = st;
        bus.req_is_byte_i  = by;
        bus.req_addr_i     = a;
        bus.req_wdata_i    = wd;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        lat = 1;
        while (!bus.resp_valid_o && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        data = bus.resp_data_o;
        err  = bus.resp_err_o;
        if (!bus.resp_valid_o) begin
            tests++;
            fails++;
            $display("FAIL resp_timeout: no response for addr 0x%08h within 20 cycles", a);
        end else if (auto_yumi) begin
            bus.resp_yumi_i = 1'b1;
            @(negedge clk);
            bus.resp_yumi_i = 1'b0;
        end
    endtask

    always @(posedge clk) begin
        if (bus.resp_yumi_i === 1'b1 && bus.resp_valid_o !== 1'b1) begin
            fails++;
            $display("FAIL yumi_protocol: resp_yumi_i high while resp_valid_o=%b", bus.resp_valid_o);
        end
    end

    vec_t vecs[15];

    initial begin
        logic [31:0] d;
        logic        e;
        int          lat;

        vecs[0]  = '{"sw_10",       1, 0, 32'h10,   32'h11223344, 32'h0,        0, 2};
        vecs[1]  = '{"lw_10",       0, 0, 32'h10,   32'h0,        32'h11223344, 0, 2};
        vecs[2]  = '{"sb_12",       1, 1, 32'h12,   32'hFFFFFFAB, 32'h0,        0, 3};
        vecs[3]  = '{"lw_10_rmw",   0, 0, 32'h10,   32'h0,        32'h11AB3344, 0, 2};
        vecs[4]  = '{"lbu_13",      0, 1, 32'h13,   32'h0,        32'h00000011, 0, 2};
        vecs[5]  = '{"lbu_10",      0, 1, 32'h10,   32'h0,        32'h00000044, 0, 2};
        vecs[6]  = '{"sw_20",       1, 0, 32'h20,   32'hCAFEF00D, 32'h0,        0, 2};
        vecs[7]  = '{"lw_22_mis",   0, 0, 32'h22,   32'h0,        32'h0,        1, 1};
        vecs[8]  = '{"lw_20",       0, 0, 32'h20,   32'h0,        32'hCAFEF00D, 0, 2};
        vecs[9]  = '{"sw_1008",     1, 0, 32'h1008, 32'h5A5A1234, 32'h0,        0, 2};
        vecs[10] = '{"lw_8_wrap",   0, 0, 32'h8,    32'h0,        32'h5A5A1234, 0, 2};
        vecs[11] = '{"sb_23",       1, 1, 32'h23,   32'h00000077, 32'h0,        0, 3};
        vecs[12] = '{"lw_20_rmw",   0, 0, 32'h20,   32'h0,        32'h77FEF00D, 0, 2};
        vecs[13] = '{"sw_41_mis",   1, 0, 32'h41,   32'h12345678, 32'h0,        1, 1};
        vecs[14] = '{"sw_40_zero",  1, 0, 32'h40,   32'h0,        32'h0,        0, 2};

        reset              = 1'b1;
        bus.req_valid_i    = 1'b0;
        bus.req_is_store_i = 1'b0;
        bus.req_is_byte_i  = 1'b0;
        bus.req_addr_i     = '0;
        bus.req_wdata_i    = '0;
        bus.resp_yumi_i    = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", {31'b0, bus.req_ready_o}, 32'd1);
        check("rst_valid", {31'b0, bus.resp_valid_o}, 32'd0);
        check("rst_err",   {31'b0, bus.resp_err_o}, 32'd0);
        check("rst_data",  bus.resp_data_o, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) begin
            do_req(vecs[i].st, vecs[i].by, vecs[i].addr, vecs[i].wdata, 1'b1, d, e, lat);
            check({vecs[i].name, "_data"}, d, vecs[i].exp_data);
            check({vecs[i].name, "_err"}, {31'b0, e}, {31'b0, vecs[i].exp_err});
            check({vecs[i].name, "_lat"}, lat, vecs[i].exp_lat);
        end

        // Hold the response for 5 cycles while a competing store is offered and ignored
        do_req(1'b0, 1'b0, 32'h10, 32'h0, 1'b0, d, e, lat);
        check("hold_first_data", d, 32'h11AB3344);
        for (int k = 0; k < 5; k++) begin
            bus.req_valid_i    = 1'b1;
            bus.req_is_store_i = 1'b1;
            bus.req_is_byte_i  = 1'b0;
            bus.req_addr_i     = 32'h10;
            bus.req_wdata_i    = 32'hDEADDEAD;
            @(negedge clk);
            check("hold_valid", {31'b0, bus.resp_valid_o}, 32'd1);
            check("hold_data",  bus.resp_data_o, 32'h11AB3344);
            check("hold_ready", {31'b0, bus.req_ready_o}, 32'd0);
        end
        bus.req_valid_i = 1'b0;
        bus.resp_yumi_i = 1'b1;
        @(negedge clk);
        bus.resp_yumi_i = 1'b0;
        check("post_yumi_ready", {31'b0, bus.req_ready_o}, 32'd1);
        check("post_yumi_valid", {31'b0, bus.resp_valid_o}, 32'd0);
        do_req(1'b0, 1'b0, 32'h10, 32'h0, 1'b1, d, e, lat);
        check("hold_store_ignored", d, 32'h11AB3344);

        // Reset asserted during the WR cycle of SW 0x40
        bus.req_valid_i    = 1'b1;
        bus.req_is_store_i = 1'b1;
        bus.req_is_byte_i  = 1'b0;
        bus.req_addr_i     = 32'h40;
        bus.req_wdata_i    = 32'hFFFFFFFF;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        check("wr_state_ready", {31'b0, bus.req_ready_o}, 32'd0);
        reset = 1'b1;
        #1;
        check("async_rst_ready", {31'b0, bus.req_ready_o}, 32'd1);
        check("async_rst_valid", {31'b0, bus.resp_valid_o}, 32'd0);
        @(negedge clk);
        check("rst_wr_data", bus.resp_data_o, 32'h0);
        check("rst_wr_err",  {31'b0, bus.resp_err_o}, 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_wr_no_resp", {31'b0, bus.resp_valid_o}, 32'd0);
        do_req(1'b0, 1'b0, 32'h40, 32'h0, 1'b1, d, e, lat);
        check("rst_wr_lw_40", d, 32'h0);
        check("rst_wr_lw_lat", lat, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
